// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes, the
// deframer FSM states and the width of one queued FIFO word.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // Each queued word carries {frame_err, parity_err, data}.
    function automatic int fifo_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; the head word reads as zero while empty.
// Occupancy is counted separately so full and empty never alias.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_wr = i_push & (~o_full | i_pop);
    assign w_rd = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: synchroniser, baud counter and deframing FSM feeding a
// FWFT receive FIFO, with a sticky overrun flag for dropped words.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        Clk,
    input  logic                        reset,
    input  logic                        R_EN,
    input  logic                        Serial,
    output logic [DATA_BITS-1:0]        Data,
    output logic                        Valid,
    input  logic                        Ready,
    output logic                        Frame_Err,
    output logic                        Parity_Err,
    output logic                        Overrun,
    input  logic                        Clear_Err,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int WORD_W = fifo_width(DATA_BITS);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic                 w_rx;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_overrun;
    logic                 w_sample;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [WORD_W-1:0]    w_word;
    logic [WORD_W-1:0]    w_head;

    assign w_rx = r_sync[1];

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], Serial};
            r_rx_prev <= w_rx;
        end
    end

    // START samples mid-bit; every later bit is sampled one full period on.
    assign w_sample = (r_state == S_START) ? (r_clk_cnt == CNT_W'(CLKS_PER_BIT/2 - 1))
                                           : (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:   if (R_EN && r_rx_prev && !w_rx) w_state_nxt = S_START;
            S_START:  if (w_sample) w_state_nxt = w_rx ? S_IDLE : S_DATA;
            S_DATA:   if (w_sample && r_bit_cnt == 4'(DATA_BITS-1))
                          w_state_nxt = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_sample) w_state_nxt = S_STOP;
            S_STOP:   if (w_sample && r_bit_cnt == 4'(STOP_BITS-1)) begin
                          w_push      = 1'b1;
                          w_state_nxt = w_rx ? S_IDLE : S_BREAK;
                      end
            S_BREAK:  if (w_rx) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_sample || r_state == S_IDLE || r_state == S_BREAK) r_clk_cnt <= '0;
            else                                                     r_clk_cnt <= r_clk_cnt + 1'b1;
            if (w_state_nxt != r_state) r_bit_cnt <= '0;
            else if (w_sample)          r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_state == S_START) begin
                r_ferr <= 1'b0;
                r_perr <= 1'b0;
            end
            if (r_state == S_DATA && w_sample)
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            // Odd parity inverts the check: an odd total is the good case.
            if (r_state == S_PARITY && w_sample)
                r_perr <= (^r_shift) ^ w_rx ^ (PARITY == PARITY_ODD);
            if (r_state == S_STOP && w_sample && !w_rx)
                r_ferr <= 1'b1;
        end
    end

    // The final stop sample goes straight into the word so it lands on the push edge.
    assign w_word = {r_ferr | ~w_rx, r_perr, r_shift};
    assign w_pop  = ~w_empty & Ready;

    uart_rx_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (Clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (Fifo_Count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)                        r_overrun <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
        else if (Clear_Err)                r_overrun <= 1'b0;
    end

    assign Valid      = ~w_empty;
    assign Data       = w_head[DATA_BITS-1:0];
    assign Parity_Err = w_head[WORD_W-2];
    assign Frame_Err  = w_head[WORD_W-1];
    assign Overrun    = r_overrun;

endmodule
